param_register_file: RTL

Parametrised successor to the CPU's 16 x 24-bit register file: configurable data width and register count, register 0 hardwired to zero, a sequential bulk-clear engine with busy indication, and an optional write-to-read bypass. It sits in the decode stage and feeds the ALU operand muxes. RS/RT read ports are combinational; the RD write port is clocked.

---
 rtl/param_register_file.sv | 104 ++++++++++
 1 files changed

// File: rtl/param_register_file.sv
// Parametrised register file: r0 hardwired to zero, sequential bulk clear.
// Optional same-cycle write-to-read bypass under `REGFILE_BYPASS_EN.
module param_register_file #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] RS,
  input  logic [ADDR_WIDTH-1:0] RT,
  input  logic [ADDR_WIDTH-1:0] RD,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  RegWrite,
  input  logic                  Clear,
  output logic [DATA_WIDTH-1:0] ReadRS,
  output logic [DATA_WIDTH-1:0] ReadRT,
  output logic                  Busy,
  output logic                  WriteDropped
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_IDLE,
    S_CLEAR
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    drop_q, drop_d;
  logic [DATA_WIDTH-1:0]   regs_q [DEPTH];
  logic [DATA_WIDTH-1:0]   regs_d [DEPTH];
  logic [DATA_WIDTH-1:0]   rs_arr, rt_arr;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (Clear) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        // Counter wraps to 0 naturally on the last register.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) regs_d[i] = regs_q[i];
    drop_d = 1'b0;
    if (state_q == S_IDLE) begin
      if (RegWrite && RD != '0) regs_d[RD] = WriteData;
    end else begin
      regs_d[cnt_q] = '0;
      drop_d        = RegWrite;
    end
  end

  always_comb begin
    Busy         = (state_q == S_CLEAR);
    WriteDropped = drop_q;
    rs_arr       = (RS == '0) ? '0 : regs_q[RS];
    rt_arr       = (RT == '0) ? '0 : regs_q[RT];
`ifdef REGFILE_BYPASS_EN
    ReadRS = rs_arr;
    ReadRT = rt_arr;
    if (state_q == S_IDLE && RegWrite && RD != '0) begin
      if (RS == RD) ReadRS = WriteData;
      if (RT == RD) ReadRT = WriteData;
    end
`else
    ReadRS = rs_arr;
    ReadRT = rt_arr;
`endif
  end

endmodule
